// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared types and constants for the CAN CRC-15 frame sequencer
package can_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_HDR,
    ST_DATA,
    ST_LATCH,
    ST_CRC,
    ST_DONE
  } can_crc_seq_state_t;

  localparam int          CAN_HDR_BITS = 19;
  localparam int          CAN_CRC_W    = 15;
  localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

endpackage

// File: rtl/can_crc15_gen.sv
// rtl/can_crc15_gen.sv - bit-serial CAN CRC-15 engine
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   crc_init  clear the running CRC (takes priority over crc_en)
//   crc_en    fold data_bit into the running CRC this cycle
//   data_bit  serial input bit
//   crc_out   running CRC register
module can_crc15_gen
  import can_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 crc_init,
  input  logic                 crc_en,
  input  logic                 data_bit,
  output logic [CAN_CRC_W-1:0] crc_out
);

  logic [CAN_CRC_W-1:0] r_crc;
  logic                 w_fb;

  // Feedback is the incoming bit XOR the bit being shifted out.
  assign w_fb = data_bit ^ r_crc[CAN_CRC_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (crc_init) begin
      r_crc <= '0;
    end else if (crc_en) begin
      r_crc <= {r_crc[CAN_CRC_W-2:0], 1'b0} ^ (w_fb ? CAN_CRC_POLY : '0);
    end
  end

  assign crc_out = r_crc;

endmodule

// File: rtl/can_crc_seq.sv
// rtl/can_crc_seq.sv - CAN base-frame serializer driving the CRC-15 engine
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         frame request, taken only while idle
//   id_in         11-bit identifier
//   rtr_in        remote frame (no data field)
//   dlc_in        data length code, transmitted as given
//   data_in       data bytes, byte0 in [63:56]
//   bit_tick      consume the current bit
//   abort         abandon the frame in progress
//   tx_bit        current serialized bit
//   tx_valid      tx_bit meaningful (header, data or CRC bits)
//   crc_phase     CRC bits are being presented
//   busy          frame in progress
//   frame_done    one-cycle pulse after the last CRC bit
//   crc_value     CRC latched for the current frame
module can_crc_seq
  import can_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int CRC_W     = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [10:0]      id_in,
  input  logic             rtr_in,
  input  logic [3:0]       dlc_in,
  input  logic [63:0]      data_in,
  input  logic             bit_tick,
  input  logic             abort,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             crc_phase,
  output logic             busy,
  output logic             frame_done,
  output logic [CRC_W-1:0] crc_value
);

  localparam logic [3:0] LP_MAX_BYTES = 4'(MAX_BYTES);
  localparam logic [6:0] LP_HDR_LAST  = 7'(CAN_HDR_BITS - 1);
  localparam logic [6:0] LP_CRC_LAST  = 7'(CAN_CRC_W - 1);

  can_crc_seq_state_t r_state, w_state_nxt;

  logic [10:0]          r_id;
  logic                 r_rtr;
  logic [3:0]           r_dlc;
  logic [63:0]          r_data;
  logic [6:0]           r_nbits;
  logic [6:0]           r_idx;
  logic [CRC_W-1:0]     r_crc_value;

  logic [3:0]           w_nbytes;
  logic [6:0]           w_nbits;
  logic [18:0]          w_hdr;
  logic [18:0]          w_hdr_sh;
  logic [63:0]          w_data_sh;
  logic [CRC_W-1:0]     w_crc_sh;
  logic                 w_crc_init;
  logic                 w_crc_en;
  logic                 w_tx_valid;
  logic                 w_tx_bit;
  logic [CAN_CRC_W-1:0] w_crc_out;

  // Data field length, clamped and suppressed for remote frames.
  assign w_nbytes = (dlc_in > LP_MAX_BYTES) ? LP_MAX_BYTES : dlc_in;
  assign w_nbits  = rtr_in ? 7'd0 : {w_nbytes, 3'b000};

  // SOF, ID, RTR, IDE, r0, DLC
  assign w_hdr = {1'b0, r_id, r_rtr, 1'b0, 1'b0, r_dlc};

  // Left-shifting by the bit index puts the current bit at each field's MSB.
  assign w_hdr_sh  = w_hdr << r_idx;
  assign w_data_sh = r_data << r_idx;
  assign w_crc_sh  = r_crc_value << r_idx;

  assign w_tx_valid = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_CRC);

  always_comb begin
    w_tx_bit = 1'b0;
    case (r_state)
      ST_HDR:  w_tx_bit = w_hdr_sh[18];
      ST_DATA: w_tx_bit = w_data_sh[63];
      ST_CRC:  w_tx_bit = w_crc_sh[CRC_W-1];
      default: w_tx_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_crc_init  = 1'b0;
    w_crc_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        w_crc_init  = 1'b1;
        w_state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (bit_tick) begin
          w_crc_en = 1'b1;
          if (r_idx == LP_HDR_LAST)
            w_state_nxt = (r_nbits != 7'd0) ? ST_DATA : ST_LATCH;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          w_crc_en = 1'b1;
          if (r_idx == r_nbits - 7'd1) w_state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: begin
        w_state_nxt = ST_CRC;
      end
      ST_CRC: begin
        if (bit_tick && (r_idx == LP_CRC_LAST)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // abort beats any tick and keeps the engine untouched
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_crc_init  = 1'b0;
      w_crc_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_id        <= '0;
      r_rtr       <= 1'b0;
      r_dlc       <= '0;
      r_data      <= '0;
      r_nbits     <= '0;
      r_idx       <= '0;
      r_crc_value <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && start) begin
        r_id    <= id_in;
        r_rtr   <= rtr_in;
        r_dlc   <= dlc_in;
        r_data  <= data_in;
        r_nbits <= w_nbits;
      end
      // Index restarts on every state change, counts consumed bits otherwise.
      if (w_state_nxt != r_state) begin
        r_idx <= '0;
      end else if (bit_tick && w_tx_valid) begin
        r_idx <= r_idx + 7'd1;
      end
      // Only a LATCH that really proceeds to CRC updates the value (not on abort).
      if ((r_state == ST_LATCH) && (w_state_nxt == ST_CRC)) begin
        r_crc_value <= CRC_W'(w_crc_out);
      end
    end
  end

  can_crc15_gen u_crc (
    .clk      (clk),
    .rst_n    (~rst),
    .crc_init (w_crc_init),
    .crc_en   (w_crc_en),
    .data_bit (w_tx_bit),
    .crc_out  (w_crc_out)
  );

  assign tx_bit     = w_tx_bit;
  assign tx_valid   = w_tx_valid;
  assign crc_phase  = (r_state == ST_CRC);
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);
  assign crc_value  = r_crc_value;

endmodule

// File: tb/tb_can_crc_seq.sv
// tb/tb_can_crc_seq.sv - randomized self-checking bench for can_crc_seq
module tb_can_crc_seq;

  logic        clk = 1'b0;
  logic        rst, start, rtr_in, bit_tick, abort;
  logic [10:0] id_in;
  logic [3:0]  dlc_in;
  logic [63:0] data_in;
  logic        tx_bit, tx_valid, crc_phase, busy, frame_done;
  logic [14:0] crc_value;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  bit          exp_q[$];
  int          n_pay;
  logic [14:0] exp_crc;
  logic [14:0] held_crc;

  always #5 clk = ~clk;

  can_crc_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .id_in      (id_in),
    .rtr_in     (rtr_in),
    .dlc_in     (dlc_in),
    .data_in    (data_in),
    .bit_tick   (bit_tick),
    .abort      (abort),
    .tx_bit     (tx_bit),
    .tx_valid   (tx_valid),
    .crc_phase  (crc_phase),
    .busy       (busy),
    .frame_done (frame_done),
    .crc_value  (crc_value)
  );

  always @(negedge clk) if (frame_done) done_cnt++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // CRC as the remainder of M(x)*x^15 divided by x^15 + 0x4599 (GF(2) long division).
  function automatic logic [14:0] crc_div(input bit q[$]);
    bit          m[$];
    logic [15:0] g;
    logic [14:0] r;
    g = 16'hC599;
    m = q;
    for (int k = 0; k < 15; k++) m.push_back(1'b0);
    for (int i = 0; i < q.size(); i++)
      if (m[i]) for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ g[15-j];
    for (int k = 0; k < 15; k++) r[14-k] = m[q.size()+k];
    return r;
  endfunction

  function automatic int frame_len(input logic rtr, input logic [3:0] dlc);
    int nb;
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    return 34 + 8 * nb;
  endfunction

  task automatic build(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                       input logic [63:0] data);
    int nb;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 10; i >= 0; i--) exp_q.push_back(id[i]);
    exp_q.push_back(rtr);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    for (int i = 3; i >= 0; i--) exp_q.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nb * 8; i++) exp_q.push_back(data[63-i]);
    n_pay   = exp_q.size();
    exp_crc = crc_div(exp_q);
    for (int i = 14; i >= 0; i--) exp_q.push_back(exp_crc[i]);
  endtask

  task automatic send(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                      input logic [63:0] data, input int abort_at, input bit noise,
                      input int rst_at, input int exp_len);
    int d0;
    build(id, rtr, dlc, data);
    chk("frame_len", 64'(exp_q.size()), 64'(exp_len));
    d0 = done_cnt;
    @(negedge clk);
    id_in = id; rtr_in = rtr; dlc_in = dlc; data_in = data; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    id_in = 11'($urandom); rtr_in = 1'($urandom); dlc_in = 4'($urandom);
    data_in = {$urandom, $urandom};
    chk("init_busy", 64'(busy), 64'd1);
    chk("init_txvalid", 64'(tx_valid), 64'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk("tx_valid", 64'(tx_valid), 64'd1);
      chk("tx_bit", 64'(tx_bit), 64'(exp_q[i]));
      chk("crc_phase", 64'(crc_phase), 64'(i >= n_pay));
      if (i >= n_pay) chk("crc_value", 64'(crc_value), 64'(exp_crc));
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_outputs", {44'd0, tx_bit, tx_valid, crc_phase, busy, frame_done, crc_value}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        held_crc = 15'd0;
        return;
      end
      bit_tick = 1'b1;
      if (i == abort_at) abort = 1'b1;
      if (noise && i == 3) begin
        start = 1'b1; id_in = 11'($urandom); rtr_in = 1'b1; dlc_in = 4'($urandom);
      end
      @(negedge clk);
      bit_tick = 1'b0; abort = 1'b0; start = 1'b0;
      if (i == abort_at) begin
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_txvalid", 64'(tx_valid), 64'd0);
        chk("abort_crc_held", 64'(crc_value), 64'(held_crc));
        @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        return;
      end
      chk("frame_done", 64'(frame_done), 64'(i == exp_q.size() - 1));
      if (noise && i == n_pay - 1) begin
        bit_tick = 1'b1;  // lands in LATCH, must be ignored
        @(negedge clk);
        bit_tick = 1'b0;
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_done_once", 64'(done_cnt), 64'(d0 + 1));
    chk("end_crc_hold", 64'(crc_value), 64'(exp_crc));
    held_crc = exp_crc;
  endtask

  initial begin
    bit          q[$];
    logic [10:0] rid;
    logic        rr;
    logic [3:0]  rd;
    logic [63:0] rdata;

    rst = 1'b1; start = 1'b0; rtr_in = 1'b0; bit_tick = 1'b0; abort = 1'b0;
    id_in = '0; dlc_in = '0; data_in = '0; held_crc = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {44'd0, tx_bit, tx_valid, crc_phase, busy, frame_done, crc_value}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {44'd0, tx_bit, tx_valid, crc_phase, busy, frame_done, crc_value}, 64'd0);

    // Pin the reference CRC model against hand-computed values.
    q = '{1'b1};
    chk("model_crc_1", 64'(crc_div(q)), 64'h4599);
    q = '{1'b1, 1'b0};
    chk("model_crc_10", 64'(crc_div(q)), 64'h4EAB);

    // All-zero frame
    send(11'h000, 1'b0, 4'h0, 64'h0, -1, 1'b0, -1, 34);
    chk("zero_crc_literal", 64'(crc_value), 64'h0000);

    // id 0x055, one data byte 0xCC
    send(11'h055, 1'b0, 4'h1, 64'hCC00_0000_0000_0000, -1, 1'b0, -1, 42);

    // Remote frame with DLC 8: header only
    send(11'($urandom), 1'b1, 4'h8, 64'hDEAD_BEEF_0123_4567, -1, 1'b0, -1, 34);

    // DLC 15 clamps to 8 data bytes
    send(11'($urandom), 1'b0, 4'hF, {$urandom, $urandom}, -1, 1'b0, -1, 98);

    // Abort on the 10th tick, then an immediate new frame
    send(11'($urandom), 1'b0, 4'h3, {$urandom, $urandom}, 9, 1'b0, -1, frame_len(1'b0, 4'h3));
    send(11'h7A5, 1'b0, 4'h2, 64'h1234_5678_9ABC_DEF0, -1, 1'b0, -1, 50);

    // start while busy and a tick during LATCH are both ignored
    send(11'h3C3, 1'b0, 4'h3, 64'hA5A5_A5FF_0000_0000, -1, 1'b1, -1, 58);

    // Random frames
    for (int n = 0; n < 8; n++) begin
      rid = 11'($urandom); rr = 1'($urandom_range(0, 3) == 0); rd = 4'($urandom);
      rdata = {$urandom, $urandom};
      send(rid, rr, rd, rdata, -1, 1'b0, -1, frame_len(rr, rd));
    end

    // Reset in the middle of the CRC bits
    send(11'h123, 1'b0, 4'h2, 64'hFFFF_0000_0000_0000, -1, 1'b0, 40, 50);
    @(negedge clk);
    chk("post_rst_crc", 64'(crc_value), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // Normal operation after reset
    send(11'($urandom), 1'b0, 4'h5, {$urandom, $urandom}, -1, 1'b0, -1, 74);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
